// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, bit shifting on device clock edges, ACK check.
// write is a one-cycle request honoured only while busy=0; done/err pulse once per accepted request.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES     = 2500,
    parameter int FIRST_EDGE_TIMEOUT = 375000,
    parameter int PACKET_TIMEOUT     = 50000,
    parameter int FILTER_LEN         = 8
) (
    input  logic        clk_25MHz,
    input  logic        reset,
    input  logic        write,
    input  logic [10:0] tx_data,
    input  logic        ps2_clk_in,
    input  logic        ps2_data_in,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int FE_W  = $clog2(FIRST_EDGE_TIMEOUT + 1);
    localparam int PKT_W = $clog2(PACKET_TIMEOUT + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [FE_W-1:0]  FE_LAST  = FE_W'(FIRST_EDGE_TIMEOUT - 1);
    localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PACKET_TIMEOUT - 1);
    localparam logic [3:0]       FLT_LAST = 4'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE, FAIL
    } state_t;

    logic [1:0] clk_sync, data_sync;
    logic       clk_filt, data_filt;
    logic [3:0] clk_cnt, data_cnt;
    logic       clk_fall;

    state_t           state, state_n;
    logic [10:0]      tx_q, tx_n;
    logic [3:0]       bit_idx, bit_n;
    logic [INH_W-1:0] inh_cnt, inh_n;
    logic [FE_W-1:0]  fe_cnt, fe_n;
    logic [PKT_W-1:0] pkt_cnt, pkt_n;
    logic             data_oe_q, data_oe_n;
    logic             done_q, done_n;
    logic             err_q, err_n;
    logic [1:0]       err_code_q, code_n;
    logic             framing_ok;

    // A filtered line only flips after FILTER_LEN consecutive opposite samples;
    // clk_fall is registered alongside the flip so it lines up with clk_filt.
    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_filt  <= 1'b1;
            data_filt <= 1'b1;
            clk_cnt   <= 4'd0;
            data_cnt  <= 4'd0;
            clk_fall  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_fall  <= 1'b0;

            if (clk_sync[1] == clk_filt) begin
                clk_cnt <= 4'd0;
            end else if (clk_cnt == FLT_LAST) begin
                clk_filt <= clk_sync[1];
                clk_cnt  <= 4'd0;
                clk_fall <= clk_filt;
            end else begin
                clk_cnt <= clk_cnt + 4'd1;
            end

            if (data_sync[1] == data_filt) begin
                data_cnt <= 4'd0;
            end else if (data_cnt == FLT_LAST) begin
                data_filt <= data_sync[1];
                data_cnt  <= 4'd0;
            end else begin
                data_cnt <= data_cnt + 4'd1;
            end
        end
    end

    assign framing_ok = ~tx_data[0] & tx_data[10] & (^tx_data[9:1]);

    always_ff @(posedge clk_25MHz) begin
        if (reset) begin
            state      <= IDLE;
            tx_q       <= 11'd0;
            bit_idx    <= 4'd0;
            inh_cnt    <= '0;
            fe_cnt     <= '0;
            pkt_cnt    <= '0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state      <= state_n;
            tx_q       <= tx_n;
            bit_idx    <= bit_n;
            inh_cnt    <= inh_n;
            fe_cnt     <= fe_n;
            pkt_cnt    <= pkt_n;
            data_oe_q  <= data_oe_n;
            done_q     <= done_n;
            err_q      <= err_n;
            err_code_q <= code_n;
        end
    end

    always_comb begin
        state_n   = state;
        tx_n      = tx_q;
        bit_n     = bit_idx;
        inh_n     = '0;
        fe_n      = '0;
        pkt_n     = '0;
        data_oe_n = 1'b0;
        done_n    = 1'b0;
        err_n     = 1'b0;
        code_n    = err_code_q;

        case (state)
            IDLE: begin
                if (write) begin
                    tx_n = tx_data;
                    if (framing_ok) begin
                        code_n  = 2'd0;
                        state_n = INHIBIT;
                    end else begin
                        code_n = 2'd1;
                        err_n  = 1'b1;
                    end
                end
            end
            INHIBIT: begin
                inh_n = inh_cnt + 1'b1;
                if (inh_cnt == INH_LAST) begin
                    state_n   = START;
                    data_oe_n = 1'b1;
                end
            end
            START: begin
                data_oe_n = 1'b1;
                bit_n     = 4'd1;
                state_n   = SHIFT;
            end
            SHIFT: begin
                data_oe_n = data_oe_q;
                // Before the first edge only the first-edge counter runs; after it, the packet counter.
                if (bit_idx == 4'd1) begin
                    fe_n = fe_cnt + 1'b1;
                end else begin
                    pkt_n = pkt_cnt + 1'b1;
                end
                if (clk_fall) begin
                    data_oe_n = ~tx_q[bit_idx];
                    bit_n     = bit_idx + 4'd1;
                    if (bit_idx == 4'd10) begin
                        state_n = ACK;
                    end
                end else if ((bit_idx == 4'd1 && fe_cnt == FE_LAST) ||
                             (bit_idx != 4'd1 && pkt_cnt == PKT_LAST)) begin
                    data_oe_n = 1'b0;
                    err_n     = 1'b1;
                    code_n    = 2'd2;
                    state_n   = FAIL;
                end
            end
            ACK: begin
                pkt_n = pkt_cnt + 1'b1;
                if (clk_fall) begin
                    if (!data_filt) begin
                        state_n = WAIT_IDLE;
                    end else begin
                        err_n   = 1'b1;
                        code_n  = 2'd3;
                        state_n = FAIL;
                    end
                end else if (pkt_cnt == PKT_LAST) begin
                    err_n   = 1'b1;
                    code_n  = 2'd2;
                    state_n = FAIL;
                end
            end
            WAIT_IDLE: begin
                pkt_n = pkt_cnt + 1'b1;
                if (clk_filt && data_filt) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end else if (pkt_cnt == PKT_LAST) begin
                    err_n   = 1'b1;
                    code_n  = 2'd2;
                    state_n = FAIL;
                end
            end
            FAIL: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign ps2_clk_oe  = (state == INHIBIT) || (state == START);
    assign ps2_data_oe = data_oe_q;
    assign busy        = (state != IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-collector device model clocking random frames, ACK/no-ACK,
// timeouts, framing errors, glitches and mid-frame reset.
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int FE   = 1000;
    localparam int PKT  = 1500;
    localparam int FLT  = 8;
    localparam int HALF = 20;

    logic        clk_25MHz = 1'b0;
    logic        reset;
    logic        write;
    logic [10:0] tx_data;
    logic        dev_clk, dev_data;
    logic        ps2_clk_in, ps2_data_in;
    logic        ps2_clk_oe, ps2_data_oe;
    logic        busy, done, err;
    logic [1:0]  err_code;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic       busy_at_done = 1'b0;
    logic [1:0] code_at_err = 2'd0;
    logic [1:0] oe_at_err = 2'd0;

    ps2_host_tx #(
        .INHIBIT_CYCLES    (INH),
        .FIRST_EDGE_TIMEOUT(FE),
        .PACKET_TIMEOUT    (PKT),
        .FILTER_LEN        (FLT)
    ) dut (
        .clk_25MHz  (clk_25MHz),
        .reset      (reset),
        .write      (write),
        .tx_data    (tx_data),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code)
    );

    // Wired-AND open-collector lines
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #20 clk_25MHz = ~clk_25MHz;

    always @(negedge clk_25MHz) begin
        if (done) begin
            done_cnt     <= done_cnt + 1;
            busy_at_done <= busy;
        end
        if (err) begin
            err_cnt     <= err_cnt + 1;
            code_at_err <= err_code;
            oe_at_err   <= {ps2_clk_oe, ps2_data_oe};
        end
        if (done && err) both_cnt <= both_cnt + 1;
    end

    function automatic logic [10:0] make_frame(input logic [7:0] b);
        return {1'b1, ~(^b), b, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_25MHz);
    endtask

    task automatic idle(input int n);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        cycles(n);
    endtask

    task automatic do_write(input logic [10:0] w);
        @(negedge clk_25MHz);
        write   = 1'b1;
        tx_data = w;
        @(negedge clk_25MHz);
        write   = 1'b0;
    endtask

    // Issues the request and checks the inhibit/start phases; returns at SHIFT entry.
    task automatic host_start(input logic [10:0] w, input bit inject);
        int n;
        do_write(w);
        chk("code_cleared", 32'(err_code), 32'd0);
        n = 0;
        while (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0 && n < INH + 20) begin
            if (inject && n == 5) begin
                write   = 1'b1;
                tx_data = ~w | 11'b10000000000;
                tx_data[0] = 1'b0;
            end else begin
                write = 1'b0;
            end
            n++;
            @(negedge clk_25MHz);
        end
        write = 1'b0;
        chk("inhibit_len", 32'(n), 32'(INH));
        chk("start_clk_oe", 32'(ps2_clk_oe), 32'd1);
        chk("start_data_oe", 32'(ps2_data_oe), 32'd1);
        @(negedge clk_25MHz);
        chk("shift_clk_rel", 32'(ps2_clk_oe), 32'd0);
        chk("shift_start_bit", 32'(ps2_data_oe), 32'd1);
    endtask

    // Device clocks nbits falling edges and checks the host's data line after each.
    task automatic dev_bits(input logic [10:0] f, input int nbits, input bit glitch);
        logic eb;
        cycles(HALF);
        chk("start_on_line", 32'(ps2_data_in), 32'd0);
        for (int k = 1; k <= nbits; k++) begin
            dev_clk = 1'b0;
            cycles(HALF);
            eb = ~f[k];
            chk($sformatf("bit%0d_oe", k), 32'(ps2_data_oe), 32'(eb));
            dev_clk = 1'b1;
            cycles(HALF);
            if (glitch && k == 4) begin
                dev_clk = 1'b0;
                cycles(3);
                dev_clk = 1'b1;
                cycles(HALF);
                chk("glitch_hold", 32'(ps2_data_oe), 32'(eb));
            end
        end
    endtask

    task automatic dev_ack(input bit ack_low);
        dev_data = ~ack_low;
        cycles(HALF);
        dev_clk = 1'b0;
        cycles(HALF);
        dev_clk = 1'b1;
        cycles(2);
        dev_data = 1'b1;
    endtask

    task automatic wait_count(input int base, input bit want_done, input string tag);
        int n;
        n = 0;
        while (((want_done ? done_cnt : err_cnt) == base) && n < 400) begin
            @(negedge clk_25MHz);
            n++;
        end
        chk(tag, 32'(n < 400), 32'd1);
    endtask

    initial begin
        logic [10:0] f;
        logic [7:0]  b;
        int d0, e0, n;
        logic seen;

        reset = 1'b1; write = 1'b0; tx_data = 11'd0; dev_clk = 1'b1; dev_data = 1'b1;
        cycles(4);
        chk("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        reset = 1'b0;
        idle(30);

        // Nominal F4 send
        f = 11'b10111101000;
        d0 = done_cnt; e0 = err_cnt;
        host_start(f, 1'b0);
        dev_bits(f, 10, 1'b0);
        dev_ack(1'b1);
        wait_count(d0, 1'b1, "f4_done_seen");
        cycles(3);
        chk("f4_done_once", 32'(done_cnt), 32'(d0 + 1));
        chk("f4_no_err", 32'(err_cnt), 32'(e0));
        chk("f4_busy_at_done", 32'(busy_at_done), 32'd0);
        chk("f4_code", 32'(err_code), 32'd0);
        idle(30);

        // Random bytes; i==1 writes during INHIBIT, i==2 glitches the clock mid-frame
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            f = make_frame(b);
            d0 = done_cnt; e0 = err_cnt;
            host_start(f, i == 1);
            dev_bits(f, 10, i == 2);
            dev_ack(1'b1);
            wait_count(d0, 1'b1, $sformatf("rand%0d_done_seen", i));
            cycles(3);
            chk($sformatf("rand%0d_done_once", i), 32'(done_cnt), 32'(d0 + 1));
            chk($sformatf("rand%0d_no_err", i), 32'(err_cnt), 32'(e0));
            idle(30);
        end

        // No ACK
        f = make_frame(8'($urandom_range(0, 255)));
        d0 = done_cnt; e0 = err_cnt;
        host_start(f, 1'b0);
        dev_bits(f, 10, 1'b0);
        dev_ack(1'b0);
        wait_count(e0, 1'b0, "noack_err_seen");
        cycles(3);
        chk("noack_code_at_err", 32'(code_at_err), 32'd3);
        chk("noack_oe_at_err", 32'(oe_at_err), 32'd0);
        chk("noack_err_once", 32'(err_cnt), 32'(e0 + 1));
        chk("noack_no_done", 32'(done_cnt), 32'(d0));
        chk("noack_code_held", 32'(err_code), 32'd3);
        idle(30);

        // First-edge timeout: device never clocks
        host_start(f, 1'b0);
        n = 0;
        while (err !== 1'b1 && n < FE + 50) begin
            @(negedge clk_25MHz);
            n++;
        end
        chk("fe_time", 32'(n), 32'(FE));
        chk("fe_code", 32'(err_code), 32'd2);
        chk("fe_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("fe_data_oe", 32'(ps2_data_oe), 32'd0);
        idle(30);

        // Framing error (bad parity)
        e0 = err_cnt;
        do_write(11'b10111101010);
        chk("frm_err", 32'(err), 32'd1);
        chk("frm_code", 32'(err_code), 32'd1);
        chk("frm_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_25MHz);
            seen = seen | busy | ps2_clk_oe | ps2_data_oe;
        end
        chk("frm_quiet", 32'(seen), 32'd0);
        chk("frm_err_once", 32'(err_cnt), 32'(e0 + 1));

        // Reset after edge 5
        f = make_frame(8'($urandom_range(0, 255)));
        host_start(f, 1'b0);
        dev_bits(f, 5, 1'b0);
        d0 = done_cnt; e0 = err_cnt;
        reset = 1'b1;
        @(negedge clk_25MHz);
        chk("mrst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("mrst_data_oe", 32'(ps2_data_oe), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_pulses", 32'({done, err}), 32'd0);
        reset = 1'b0;
        idle(100);
        chk("mrst_no_done", 32'(done_cnt), 32'(d0));
        chk("mrst_no_err", 32'(err_cnt), 32'(e0));
        chk("mrst_idle", 32'(busy), 32'd0);

        chk("done_err_exclusive", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
